// File: rtl/btn_step_ctrl_pkg.sv
// Shared constants, state encoding and sizing helpers for the button /
// single-step controller.
package btn_step_ctrl_pkg;

   // Board clock and the default timing windows derived from it
   localparam int CLK_HZ              = 12000000;
   localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
   localparam int DEF_HOLD_CYCLES     = CLK_HZ / 2;     // 0.5 s
   localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 10;    // 0.1 s

   // Step controller states
   typedef enum logic [1:0] {
      ST_RUN         = 2'd0,
      ST_STEP_IDLE   = 2'd1,
      ST_STEP_HOLD   = 2'd2,
      ST_STEP_REPEAT = 2'd3
   } step_state_t;

   // Width of a counter that must hold values 0 .. n-1 (at least one bit)
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Larger of two integers, used to size the shared hold/repeat timer
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: two-flop synchroniser, stability counter,
// debounced level and single-cycle press/release pulses.
module btn_debounce
   import btn_step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic CLK,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int               CNT_W    = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;
   logic             stable;

   // Two-flop synchroniser; the raw pin only ever reaches sync_p0
   always_ff @(posedge CLK) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES
   // consecutive cycles; any agreeing cycle restarts the count. The edge
   // pulses are registered together with the level so they line up.
   always_ff @(posedge CLK) begin
      if (reset) begin
         cnt         <= '0;
         stable      <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt         <= '0;
            stable      <= sync_p1;
            btn_press   <= sync_p1;
            btn_release <= ~sync_p1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign btn_level = stable;

endmodule

// File: rtl/btn_step_ctrl.sv
// Button front end for the core: debounces every board button and turns
// the step / mode buttons into a run or single-step clock enable, with
// hold-to-auto-repeat on the step button and a running step counter.
module btn_step_ctrl
   import btn_step_ctrl_pkg::*;
#(
   parameter int NBTN            = 3,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int STEP_IDX        = 0,
   parameter int MODE_IDX        = 1
)(
   input  logic            CLK,
   input  logic            reset,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic            step_en,
   output logic            run_mode,
   output logic [15:0]     step_count
);

   // Shared hold / repeat timer sized for the longer of the two windows
   localparam int               TMR_W     = cnt_w(max2(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

   // Reject parameter sets the timing logic cannot honour
   if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
      $error("btn_step_ctrl: DEBOUNCE_CYCLES must be >= 2");
   end
   if (HOLD_CYCLES < 2) begin : g_chk_hold
      $error("btn_step_ctrl: HOLD_CYCLES must be >= 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_chk_rep
      $error("btn_step_ctrl: REPEAT_CYCLES must be >= 2");
   end
   if (STEP_IDX < 0 || STEP_IDX >= NBTN || MODE_IDX < 0 || MODE_IDX >= NBTN
       || STEP_IDX == MODE_IDX) begin : g_chk_idx
      $error("btn_step_ctrl: STEP_IDX / MODE_IDX must be distinct buttons");
   end

   // One conditioner per button
   for (genvar i = 0; i < NBTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .CLK         (CLK),
         .reset       (reset),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

   step_state_t      state;
   step_state_t      state_nxt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;
   logic             step_en_nxt;
   logic             mode_press;
   logic             step_press;
   logic             step_level;

   assign mode_press = btn_press[MODE_IDX];
   assign step_press = btn_press[STEP_IDX];
   assign step_level = btn_level[STEP_IDX];

   // Next state, timer and enable; a mode press overrides any step
   // activity, and a released step button overrides timer expiry.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      step_en_nxt = 1'b0;
      if (mode_press) begin
         state_nxt = (state == ST_RUN) ? ST_STEP_IDLE : ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               state_nxt = ST_RUN;
            end
            ST_STEP_IDLE: begin
               if (step_press) begin
                  step_en_nxt = 1'b1;
                  timer_nxt   = '0;
                  state_nxt   = ST_STEP_HOLD;
               end
            end
            ST_STEP_HOLD: begin
               if (!step_level) begin
                  state_nxt = ST_STEP_IDLE;
               end else if (timer == HOLD_LAST) begin
                  step_en_nxt = 1'b1;
                  timer_nxt   = '0;
                  state_nxt   = ST_STEP_REPEAT;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
            ST_STEP_REPEAT: begin
               if (!step_level) begin
                  state_nxt = ST_STEP_IDLE;
               end else if (timer == REP_LAST) begin
                  step_en_nxt = 1'b1;
                  timer_nxt   = '0;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
            default: begin
               state_nxt = ST_STEP_IDLE;
            end
         endcase
      end
      if (state_nxt == ST_RUN) begin
         step_en_nxt = 1'b1;
      end
   end

   // State, timer and registered enable / mode outputs
   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= ST_STEP_IDLE;
         timer    <= '0;
         step_en  <= 1'b0;
         run_mode <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         step_en  <= step_en_nxt;
         run_mode <= (state_nxt == ST_RUN);
      end
   end

   // Count every enabled core cycle; wraps naturally at 16 bits
   always_ff @(posedge CLK) begin
      if (reset) begin
         step_count <= '0;
      end else if (step_en) begin
         step_count <= step_count + 16'd1;
      end
   end

endmodule
